twos_conv_serial: RTL
=====================

# twos_conv_serial

Parametrised bit-serial two's-complement conversion unit, successor to the fixed 4-bit combinational converter in the PCFG arithmetic path. It accepts one WIDTH-bit operand per transaction and applies one of four modes: pass, negate, absolute value, or sign-magnitude to two's-complement. It processes one bit per clock, LSB first, with the "copy through first 1, then invert" rule, and has valid/ready handshakes on both sides. It sits between operand registers and the accumulator datapath, where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/mode offered
- in_ready  output  1  unit can accept; high only in IDLE
- operand  input  WIDTH  input word
- mode  input  2  00 PASS, 01 NEG, 10 ABS, 11 SM2TC
- out_valid  output  1  result available; held until taken
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  converted word; stable while out_valid
- ovf  output  1  present only with TWOS_CONV_OVF_EN; see Configuration

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a rising edge (accept): latch operand into the shift register and sample mode.
  - Compute inv: NEG→1, ABS→operand[WIDTH-1], SM2TC→operand[WIDTH-1], PASS→0.
  - Clear seen_one; set bit counter to 0; go to SHIFT.
- SHIFT: one bit per edge, LSB first.
  - Input bit b = shift_reg[0]; in SM2TC the MSB step forces b=0, so the magnitude is zero-extended.
  - Output bit = (inv & seen_one) ? ~b : b.
  - seen_one |= b.
  - The output bit shifts into result at the MSB end.
  - After bit WIDTH-1: go to DONE.
- DONE: out_valid=1; result and ovf held. On out_ready: go to IDLE.
- Mode and operand changes after accept are ignored until the next accept.
- Arithmetic is modulo 2^WIDTH:
  - NEG/ABS of 100…0 yields 100…0 (wrap).
  - SM2TC of negative zero (100…0) yields 0.
- Reset (any state, including mid-SHIFT) has immediate effect:
  - State→IDLE; result, counter, shift register, seen_one, inv, ovf cleared.
  - The in-flight operation is discarded; no partial result is ever presented.
- Reset values: in_ready=1, out_valid=0, result=0, ovf=0.

## Timing
- Accept at edge k. Bits are processed at edges k+1 … k+WIDTH.
- out_valid rises after edge k+WIDTH, i.e. WIDTH cycles after accept.
- Handshake completes at the first edge with out_valid & out_ready; in_ready is high in the following cycle.
- Minimum spacing between accepts is WIDTH+2 cycles, with out_ready held high.
- in_valid and out_ready have no combinational path to any output. in_ready and out_valid are decoded from state only.
- out_ready asserted before out_valid has no effect.
- in_valid asserted while busy is not accepted. The source must hold operand and mode until in_ready.

## Configuration
- TWOS_CONV_OVF_EN defined:
  - ovf port and its register are present.
  - ovf is set at the MSB step when mode is NEG or ABS, inv=1, seen_one=0 before the step, and b=1 (operand = 100…0).
  - ovf is valid with out_valid and cleared on the next accept.
  - PASS and SM2TC never set ovf.
- TWOS_CONV_OVF_EN undefined: no ovf port and no overflow logic; results are identical otherwise.

## Test plan
All scenarios use WIDTH=8.
- NEG 0x05 accepted at edge k → out_valid after edge k+8, result=0xFB, ovf=0; in_ready low throughout cycles k+1…k+8.
- NEG 0x80 → result=0x80, ovf=1 (with macro). ABS 0x80 → 0x80, ovf=1. NEG 0x00 → 0x00, ovf=0.
- ABS 0xF6 → 0x0A. ABS 0x3C → 0x3C. PASS 0xA5 → 0xA5. Change mode and operand during SHIFT → result unchanged.
- SM2TC 0x85 → 0xFB. SM2TC 0x05 → 0x05. SM2TC 0x80 → 0x00. SM2TC 0xFF → 0x81.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and result stable, in_valid ignored. Release → handshake, in_ready=1 next cycle; back-to-back accepts spaced 10 cycles.
- Assert rst_n=0 at bit 3 of SHIFT → out_valid=0, result=0, in_ready=1 immediately. A fresh NEG 0x01 after release → 0xFF after 8 cycles.

Source files
------------

// File: rtl/twos_conv_serial.sv
// Bit-serial two's-complement converter: PASS / NEG / ABS / SM2TC, one bit per clock, LSB first.
// Latency: result valid WIDTH cycles after accept; accepts spaced at least WIDTH+2 cycles apart.
// Backpressure: result and ovf held in DONE until out_ready; in_ready is high only in IDLE.
// Optional overflow flag output enabled by defining TWOS_CONV_OVF_EN.
module twos_conv_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef TWOS_CONV_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] M_PASS  = 2'b00;
  localparam logic [1:0] M_NEG   = 2'b01;
  localparam logic [1:0] M_ABS   = 2'b10;
  localparam logic [1:0] M_SM2TC = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [1:0]       mode_q;
  logic             inv;
  logic             seen_one;

  logic             accept;
  logic             last;
  logic             bit_in;
  logic             bit_out;
  logic             inv_next;

  // Handshake flags come straight from state so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);

  // Invert decision for the new operand: always for NEG, by sign for ABS and SM2TC.
  always_comb begin
    inv_next = 1'b0;
    case (mode)
      M_NEG:          inv_next = 1'b1;
      M_ABS, M_SM2TC: inv_next = operand[WIDTH-1];
      default:        inv_next = 1'b0;
    endcase
  end

  // Per-step bit: SM2TC drops the sign bit so the magnitude is zero-extended,
  // then bits after the first 1 are inverted when negating.
  always_comb begin
    last   = (cnt == LAST);
    bit_in = shreg[0];
    if (mode_q == M_SM2TC && last) begin
      bit_in = 1'b0;
    end
    bit_out = (inv && seen_one) ? ~bit_in : bit_in;
  end

  // Control FSM plus serial datapath; result fills from the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      result   <= '0;
      cnt      <= '0;
      mode_q   <= M_PASS;
      inv      <= 1'b0;
      seen_one <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= operand;
            mode_q   <= mode;
            inv      <= inv_next;
            seen_one <= 1'b0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          result   <= {bit_out, result[WIDTH-1:1]};
          shreg    <= {1'b0, shreg[WIDTH-1:1]};
          seen_one <= seen_one | bit_in;
          cnt      <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TWOS_CONV_OVF_EN
  // Overflow: negating the most negative value, seen as a 1 at the MSB with no earlier 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (state == SHIFT && last && (mode_q == M_NEG || mode_q == M_ABS) &&
                 inv && !seen_one && bit_in) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule
